// File: rtl/tdc_pkg.sv
// Shared types and defaults for the tdc measurement sequencer.
// Holds the FSM state enum, default widths and the min-tracker init value.
package tdc_pkg;

  localparam int TDC_CW = 32;
  localparam int TDC_NW = 8;
  localparam int TDC_DW = 8;

  // Min tracker starts saturated so the first capture always replaces it.
  localparam logic [63:0] MIN_INIT = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/tdc_stats.sv
// Result accumulator: count, sum, min and max of captured tdc values.
// Ports: clk/reset, clr (restart stats), cap (add t), t, count/sum/min_v/max_v.
module tdc_stats
  import tdc_pkg::*;
#(
  parameter int CW = TDC_CW,
  parameter int NW = TDC_NW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             cap,
  input  logic [CW-1:0]    t,
  output logic [NW-1:0]    count,
  output logic [CW+NW-1:0] sum,
  output logic [CW-1:0]    min_v,
  output logic [CW-1:0]    max_v
);

  logic [NW-1:0]    count_q, count_d;
  logic [CW+NW-1:0] sum_q, sum_d;
  logic [CW-1:0]    min_q, min_d;
  logic [CW-1:0]    max_q, max_d;

  always_comb begin
    count_d = count_q;
    sum_d   = sum_q;
    min_d   = min_q;
    max_d   = max_q;
    if (clr) begin
      count_d = '0;
      sum_d   = '0;
      min_d   = MIN_INIT[CW-1:0];
      max_d   = '0;
    end else if (cap) begin
      count_d = count_q + NW'(1);
      sum_d   = sum_q + {{NW{1'b0}}, t};
      min_d   = (t < min_q) ? t : min_q;
      max_d   = (t > max_q) ? t : max_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      sum_q   <= '0;
      min_q   <= MIN_INIT[CW-1:0];
      max_q   <= '0;
    end else begin
      count_q <= count_d;
      sum_q   <= sum_d;
      min_q   <= min_d;
      max_q   <= max_d;
    end
  end

  assign count = count_q;
  assign sum   = sum_q;
  assign min_v = min_q;
  assign max_v = max_q;

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer: arms the tdc, waits for N bursts, collects stats.
// Ports: start/abort/n_meas/timeout_cycles in, uart_data/tdc_t observed,
// tdc_reset drives the tdc, busy/done/timeout_err status, stats outputs.
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter int CW = TDC_CW,
  parameter int NW = TDC_NW,
  parameter int DW = TDC_DW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [NW-1:0]    n_meas,
  input  logic [CW-1:0]    timeout_cycles,
  input  logic [DW-1:0]    uart_data,
  input  logic [CW-1:0]    tdc_t,
  output logic             tdc_reset,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [NW-1:0]    meas_count,
  output logic [CW+NW-1:0] sum_t,
  output logic [CW-1:0]    min_t,
  output logic [CW-1:0]    max_t
);

  state_e state_q, state_d;

  logic          prev_nz_q, prev_nz_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [NW-1:0] n_q, n_d;
  logic          err_q, err_d;

  logic clr, cap, ld, set_err;
  logic fall, last, tmo_hit;

  assign fall    = prev_nz_q & (uart_data == '0);
  assign last    = (meas_count + NW'(1)) == n_q;
  assign tmo_hit = (tmo_q != '0) && (timer_q == tmo_q - CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Abort is tested first in every busy state so it beats all other exits.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    cap     = 1'b0;
    ld      = 1'b0;
    set_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          ld      = 1'b1;
          state_d = (n_meas == '0) ? ST_DONE : ST_ARM;
        end
      end
      ST_ARM: begin
        if (abort)                 state_d = ST_IDLE;
        else if (uart_data == '0)  state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (abort)     state_d = ST_IDLE;
        else if (fall) state_d = ST_CAPTURE;
        else if (tmo_hit) begin
          set_err = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_CAPTURE: begin
        if (abort) state_d = ST_IDLE;
        else begin
          cap     = 1'b1;
          state_d = last ? ST_DONE : ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Timer only runs in WAIT, so every WAIT entry starts from zero.
  always_comb begin
    prev_nz_d = (uart_data != '0);
    timer_d   = (state_q == ST_WAIT) ? timer_q + CW'(1) : '0;
    n_d       = ld ? n_meas : n_q;
    tmo_d     = ld ? timeout_cycles : tmo_q;
    err_d     = err_q;
    if (ld)           err_d = 1'b0;
    else if (set_err) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_nz_q <= 1'b0;
      timer_q   <= '0;
      tmo_q     <= '0;
      n_q       <= '0;
      err_q     <= 1'b0;
    end else begin
      prev_nz_q <= prev_nz_d;
      timer_q   <= timer_d;
      tmo_q     <= tmo_d;
      n_q       <= n_d;
      err_q     <= err_d;
    end
  end

  // The tdc runs only while waiting for or capturing a burst.
  always_comb begin
    tdc_reset   = 1'b1;
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE);
    timeout_err = err_q;
    if (state_q == ST_WAIT || state_q == ST_CAPTURE)
      tdc_reset = 1'b0;
  end

  tdc_stats #(
    .CW(CW),
    .NW(NW)
  ) u_stats (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .cap  (cap),
    .t    (tdc_t),
    .count(meas_count),
    .sum  (sum_t),
    .min_v(min_t),
    .max_v(max_t)
  );

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Bench for tdc_meas_ctrl with a behavioural tdc and a transaction-level
// reference model checked every cycle, plus directed literal checks.
module tb_tdc_meas_ctrl;

  localparam int CW = 32;
  localparam int NW = 8;
  localparam int DW = 8;

  localparam int P_IDLE = 0;
  localparam int P_ARM  = 1;
  localparam int P_WAIT = 2;
  localparam int P_CAP  = 3;
  localparam int P_DONE = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [NW-1:0]    n_meas = '0;
  logic [CW-1:0]    timeout_cycles = '0;
  logic [DW-1:0]    uart_data = '0;
  logic [CW-1:0]    tdc_t;
  logic             tdc_reset;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic [NW-1:0]    meas_count;
  logic [CW+NW-1:0] sum_t;
  logic [CW-1:0]    min_t;
  logic [CW-1:0]    max_t;

  tdc_meas_ctrl #(.CW(CW), .NW(NW), .DW(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .n_meas        (n_meas),
    .timeout_cycles(timeout_cycles),
    .uart_data     (uart_data),
    .tdc_t         (tdc_t),
    .tdc_reset     (tdc_reset),
    .busy          (busy),
    .done          (done),
    .timeout_err   (timeout_err),
    .meas_count    (meas_count),
    .sum_t         (sum_t),
    .min_t         (min_t),
    .max_t         (max_t)
  );

  always #5 clk = ~clk;

  // Behavioural tdc: counts non-zero cycles, latches width on the fall.
  logic [CW-1:0] tdc_cnt = '0;
  logic [CW-1:0] tdc_lat = '0;
  always @(posedge clk) begin
    if (tdc_reset) begin
      tdc_cnt <= '0;
      tdc_lat <= '0;
    end else if (uart_data != '0) begin
      tdc_cnt <= tdc_cnt + 1;
    end else begin
      if (tdc_cnt != '0) tdc_lat <= tdc_cnt;
      tdc_cnt <= '0;
    end
  end
  assign tdc_t = tdc_lat;

  // Reference model: run phase plus list of captured burst widths.
  int    ph = P_IDLE;
  int    caps[$];
  bit    m_err = 0;
  int    m_target = 0;
  longint m_tmo = 0;
  longint m_waited = 0;
  int    m_run = 0;
  int    m_pend = 0;
  bit    m_prev = 0;
  int    n_done = 0;

  int cyc_chk = 0, cyc_fail = 0;
  int lit_chk = 0, lit_fail = 0;

  function automatic longint e_sum();
    longint s = 0;
    foreach (caps[i]) s += caps[i];
    return s;
  endfunction

  function automatic longint e_min();
    longint m = 64'h0000_0000_FFFF_FFFF;
    foreach (caps[i]) if (caps[i] < m) m = caps[i];
    return m;
  endfunction

  function automatic longint e_max();
    longint m = 0;
    foreach (caps[i]) if (caps[i] > m) m = caps[i];
    return m;
  endfunction

  task automatic m_reset();
    ph = P_IDLE;
    caps.delete();
    m_err = 0;
    m_prev = 0;
    m_run = 0;
    m_waited = 0;
  endtask

  task automatic m_step();
    bit fall;
    fall = m_prev && (uart_data == 0);
    case (ph)
      P_IDLE: if (start) begin
        caps.delete();
        m_err = 0;
        m_target = int'(n_meas);
        m_tmo = longint'(timeout_cycles);
        ph = (n_meas == 0) ? P_DONE : P_ARM;
      end
      P_ARM: begin
        if (abort) ph = P_IDLE;
        else if (uart_data == 0) begin
          ph = P_WAIT;
          m_waited = 0;
        end
      end
      P_WAIT: begin
        if (abort) ph = P_IDLE;
        else if (fall) begin
          m_pend = m_run;
          ph = P_CAP;
        end else begin
          m_waited++;
          if (m_tmo != 0 && m_waited == m_tmo) begin
            m_err = 1;
            ph = P_DONE;
          end
        end
      end
      P_CAP: begin
        if (abort) ph = P_IDLE;
        else begin
          caps.push_back(m_pend);
          if (caps.size() == m_target) ph = P_DONE;
          else begin
            ph = P_WAIT;
            m_waited = 0;
          end
        end
      end
      default: ph = P_IDLE;
    endcase
    m_run = (uart_data != 0) ? m_run + 1 : 0;
    m_prev = (uart_data != 0);
  endtask

  task automatic ck(string name, logic [63:0] act, logic [63:0] exp);
    cyc_chk++;
    if (act !== exp) begin
      cyc_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always begin
    @(posedge clk or posedge reset);
    if (reset) m_reset();
    else m_step();
    #1;
    if (done === 1'b1) n_done++;
    ck("busy", 64'(busy), 64'(ph != P_IDLE));
    ck("done", 64'(done), 64'(ph == P_DONE));
    ck("tdc_reset", 64'(tdc_reset), 64'(!(ph == P_WAIT || ph == P_CAP)));
    ck("timeout_err", 64'(timeout_err), 64'(m_err));
    ck("meas_count", 64'(meas_count), 64'(caps.size()));
    ck("sum_t", 64'(sum_t), e_sum());
    ck("min_t", 64'(min_t), e_min());
    ck("max_t", 64'(max_t), e_max());
  end

  task automatic lit(string name, logic [63:0] act, logic [63:0] exp);
    lit_chk++;
    if (act !== exp) begin
      lit_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(logic [DW-1:0] v);
    uart_data = v;
    @(negedge clk);
  endtask

  task automatic burst(int nz, int z);
    for (int i = 0; i < nz; i++) hold(DW'(i % 200 + 1));
    for (int i = 0; i < z; i++) hold('0);
  endtask

  task automatic do_start(int n, int tmo);
    start = 1'b1;
    n_meas = NW'(n);
    timeout_cycles = CW'(tmo);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    lit("wait_idle", 64'(busy), 64'd0);
  endtask

  int d0;
  int k;

  initial begin
    @(negedge clk);
    @(negedge clk);
    lit("rst_busy", 64'(busy), 64'd0);
    lit("rst_tdc_reset", 64'(tdc_reset), 64'd1);
    lit("rst_min", 64'(min_t), 64'hFFFF_FFFF);
    reset = 1'b0;
    @(negedge clk);

    // Three bursts 5/2/9
    d0 = n_done;
    do_start(3, 0);
    burst(0, 2);
    burst(5, 4);
    burst(2, 4);
    burst(9, 4);
    wait_idle(20);
    lit("s1_count", 64'(meas_count), 64'd3);
    lit("s1_sum", 64'(sum_t), 64'd16);
    lit("s1_min", 64'(min_t), 64'd2);
    lit("s1_max", 64'(max_t), 64'd9);
    lit("s1_err", 64'(timeout_err), 64'd0);
    lit("s1_done", 64'(n_done - d0), 64'd1);

    // Start mid-burst: the in-progress burst is skipped
    hold(8'h11);
    hold(8'h22);
    uart_data = 8'h33;
    do_start(1, 0);
    burst(3, 4);
    burst(4, 4);
    wait_idle(20);
    lit("s2_count", 64'(meas_count), 64'd1);
    lit("s2_min", 64'(min_t), 64'd4);
    lit("s2_max", 64'(max_t), 64'd4);

    // Timeout on the second burst
    do_start(2, 20);
    burst(0, 2);
    burst(3, 0);
    k = 0;
    while (!done && k < 60) begin
      hold('0);
      k++;
    end
    lit("s3_latency", 64'(k), 64'd22);
    lit("s3_err", 64'(timeout_err), 64'd1);
    lit("s3_count", 64'(meas_count), 64'd1);
    lit("s3_sum", 64'(sum_t), 64'd3);
    burst(0, 2);

    // Abort in WAIT after one capture
    d0 = n_done;
    do_start(3, 0);
    burst(0, 2);
    burst(7, 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    lit("s4_busy", 64'(busy), 64'd0);
    lit("s4_count", 64'(meas_count), 64'd1);
    lit("s4_sum", 64'(sum_t), 64'd7);
    lit("s4_done", 64'(n_done - d0), 64'd0);
    do_start(1, 0);
    lit("s4_clr_count", 64'(meas_count), 64'd0);
    lit("s4_clr_sum", 64'(sum_t), 64'd0);
    lit("s4_clr_min", 64'(min_t), 64'hFFFF_FFFF);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    lit("s4_abort2", 64'(busy), 64'd0);

    // n_meas = 0
    d0 = n_done;
    do_start(0, 0);
    lit("s5_busy1", 64'(busy), 64'd1);
    lit("s5_done1", 64'(done), 64'd1);
    @(negedge clk);
    lit("s5_busy0", 64'(busy), 64'd0);
    lit("s5_min", 64'(min_t), 64'hFFFF_FFFF);
    lit("s5_max", 64'(max_t), 64'd0);
    lit("s5_done", 64'(n_done - d0), 64'd1);

    // Start while busy is ignored
    d0 = n_done;
    do_start(2, 0);
    burst(0, 2);
    burst(3, 2);
    start = 1'b1;
    n_meas = 8'd5;
    @(negedge clk);
    start = 1'b0;
    burst(4, 4);
    wait_idle(20);
    lit("s6_count", 64'(meas_count), 64'd2);
    lit("s6_sum", 64'(sum_t), 64'd7);
    lit("s6_done", 64'(n_done - d0), 64'd1);

    // Async reset mid-WAIT
    do_start(2, 0);
    burst(0, 2);
    burst(4, 2);
    #2 reset = 1'b1;
    #1;
    lit("ar_busy", 64'(busy), 64'd0);
    lit("ar_tdc_reset", 64'(tdc_reset), 64'd1);
    lit("ar_count", 64'(meas_count), 64'd0);
    lit("ar_sum", 64'(sum_t), 64'd0);
    lit("ar_min", 64'(min_t), 64'hFFFF_FFFF);
    lit("ar_max", 64'(max_t), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    burst(0, 2);
    lit("ar_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed",
             (cyc_chk + lit_chk) - (cyc_fail + lit_fail),
             cyc_chk + lit_chk);
    $finish;
  end

endmodule
